// File: rtl/arith_shift_sequencer_if.sv
// Start/done handshake and result bus for arith_shift_sequencer.
// master drives the request, slave (the sequencer) returns status and result.
interface arith_shift_sequencer_if #(
   parameter int N     = 8,
   parameter int AMT_W = 4
);
   logic             start;
   logic [1:0]       op;
   logic [AMT_W-1:0] amt;
   logic [N-1:0]     din;
   logic             busy;
   logic             done;
   logic [N-1:0]     dout;
   logic [AMT_W-1:0] count;
   logic             zero;

   modport master (output start, op, amt, din,
                   input  busy, done, dout, count, zero);
   modport slave  (input  start, op, amt, din,
                   output busy, done, dout, count, zero);
endinterface

// File: rtl/arith_shift_sequencer.sv
// Multi-cycle SHL/SHR/PASS sequencer taking at most two bit positions per clock.
// Define ARITH_SHIFT_NORMALIZE_EN to make op=10 left-justify the operand (else it is PASS).
module arith_shift_sequencer #(
   parameter int N     = 8,
   parameter int AMT_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   arith_shift_sequencer_if.slave bus
);

   localparam logic [1:0] OP_SHL = 2'b00;
   localparam logic [1:0] OP_SHR = 2'b01;
`ifdef ARITH_SHIFT_NORMALIZE_EN
   localparam logic [1:0] OP_NORM = 2'b10;
`endif
   localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N);
   localparam logic [AMT_W-1:0] TWO   = AMT_W'(2);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [N-1:0]     work;
   logic [1:0]       op_r;
   logic [AMT_W-1:0] rem;
   logic [AMT_W-1:0] cnt;
   logic             busy_r, done_r, zero_r;
   logic [N-1:0]     dout_r;
   logic [AMT_W-1:0] count_r;
   logic [AMT_W-1:0] eff_amt;
   logic             is_shift;

   // Amounts of N or more all reduce to "shift everything out".
   assign eff_amt  = (bus.amt >= N_AMT) ? N_AMT : bus.amt;
   assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR);

   function automatic logic [N-1:0] shift_step(input logic [N-1:0] w,
                                               input logic left, input logic two);
      if (left)
         return two ? {w[N-3:0], 2'b00} : {w[N-2:0], 1'b0};
      else
         return two ? {2'b00, w[N-1:2]} : {1'b0, w[N-1:1]};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         work    <= '0;
         op_r    <= '0;
         rem     <= '0;
         cnt     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         zero_r  <= 1'b0;
         dout_r  <= '0;
         count_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  work   <= bus.din;
                  op_r   <= bus.op;
                  rem    <= is_shift ? eff_amt : '0;
                  cnt    <= is_shift ? eff_amt : '0;
                  busy_r <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
`ifdef ARITH_SHIFT_NORMALIZE_EN
               if (op_r == OP_NORM) begin
                  // A zero operand can never become justified, so finish at once.
                  if (work[N-1] || (work == '0)) begin
                     state   <= DONE;
                     done_r  <= 1'b1;
                     dout_r  <= work;
                     count_r <= cnt;
                     zero_r  <= (work == '0);
                  end else begin
                     work <= {work[N-2:0], 1'b0};
                     cnt  <= cnt + 1'b1;
                  end
               end else
`endif
               if (rem == '0) begin
                  state   <= DONE;
                  done_r  <= 1'b1;
                  dout_r  <= work;
                  count_r <= cnt;
                  zero_r  <= (work == '0);
               end else if (rem >= TWO) begin
                  work <= shift_step(work, op_r == OP_SHL, 1'b1);
                  rem  <= rem - TWO;
               end else begin
                  work <= shift_step(work, op_r == OP_SHL, 1'b0);
                  rem  <= rem - 1'b1;
               end
            end
            DONE: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.dout  = dout_r;
   assign bus.count = count_r;
   assign bus.zero  = zero_r;

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Scoreboarded bench for arith_shift_sequencer: expected results are queued at start
// acceptance and compared (value and latency) when done pulses.
module tb_arith_shift_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   arith_shift_sequencer_if #(.N(8), .AMT_W(4)) bif ();
   arith_shift_sequencer #(.N(8), .AMT_W(4)) dut (.clk(clk), .reset(reset), .bus(bif));

   typedef struct {
      logic [7:0] dout;
      logic [3:0] count;
      logic       zero;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t model(input logic [1:0] op, input logic [3:0] amt,
                                  input logic [7:0] din);
      exp_t e;
      int   eff;
      int   lz;
      eff     = (amt > 4'd8) ? 8 : int'(amt);
      e.dout  = din;
      e.count = 4'd0;
      e.lat   = 1;
      if (op == 2'b00) begin
         e.dout  = din << eff;
         e.count = 4'(eff);
         e.lat   = (eff + 1) / 2 + 1;
      end else if (op == 2'b01) begin
         e.dout  = din >> eff;
         e.count = 4'(eff);
         e.lat   = (eff + 1) / 2 + 1;
      end
`ifdef ARITH_SHIFT_NORMALIZE_EN
      else if (op == 2'b10 && din != 8'h00) begin
         lz = 0;
         for (int b = 7; b >= 0; b--) begin
            if (din[b]) break;
            lz++;
         end
         e.dout  = din << lz;
         e.count = 4'(lz);
         e.lat   = lz + 1;
      end
`endif
      e.zero = (e.dout == 8'h00);
      return e;
   endfunction

   // Drive one start pulse; returns at the falling edge just after the accepting edge E0.
   task automatic issue(input logic [1:0] op, input logic [3:0] amt, input logic [7:0] din);
      @(negedge clk);
      bif.start = 1'b1;
      bif.op    = op;
      bif.amt   = amt;
      bif.din   = din;
      @(posedge clk);
      sb.push_back(model(op, amt, din));
      @(negedge clk);
      bif.start = 1'b0;
      bif.op    = ~op;
      bif.amt   = ~amt;
      bif.din   = ~din;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (bif.done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bif.start = 1'b0; bif.op = 2'b00; bif.amt = 4'd0; bif.din = 8'h00;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({bif.busy, bif.done, bif.dout, bif.count, bif.zero} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b dout=%h count=%0d zero=%b, want all 0",
                  bif.busy, bif.done, bif.dout, bif.count, bif.zero);
      end
      reset = 1'b0;
   endtask

   task automatic test_shl;
      exp_t e; int k;
      issue(2'b00, 4'd3, 8'h03);
      n_tests++;
      if (bif.busy !== 1'b1) begin
         n_fail++; $display("FAIL shl_busy: busy=%b want 1", bif.busy);
      end
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== e.lat || e.lat !== 3) begin
         n_fail++; $display("FAIL shl_latency: got %0d want 3", k);
      end
      n_tests++;
      if (bif.dout !== 8'h18 || bif.count !== 4'd3 || bif.zero !== 1'b0 || bif.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL shl_result: dout=%h count=%0d zero=%b busy=%b want 18/3/0/1",
                  bif.dout, bif.count, bif.zero, bif.busy);
      end
      @(negedge clk);
      n_tests++;
      if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.dout !== 8'h18) begin
         n_fail++;
         $display("FAIL shl_after: busy=%b done=%b dout=%h want 0/0/18", bif.busy, bif.done, bif.dout);
      end
   endtask

   task automatic test_shr_clamp;
      exp_t e; int k;
      issue(2'b01, 4'd9, 8'hF0);
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== 5) begin
         n_fail++; $display("FAIL shr_clamp_latency: got %0d want 5", k);
      end
      n_tests++;
      if (bif.dout !== e.dout || bif.count !== 4'd8 || bif.zero !== 1'b1) begin
         n_fail++;
         $display("FAIL shr_clamp_result: dout=%h count=%0d zero=%b want 00/8/1",
                  bif.dout, bif.count, bif.zero);
      end
   endtask

   task automatic test_pass_busy;
      exp_t e; int k; int extra;
      issue(2'b11, 4'd5, 8'hA5);
      bif.start = 1'b1; bif.op = 2'b00; bif.amt = 4'd1; bif.din = 8'h77;
      @(negedge clk);
      bif.start = 1'b0;
      k = 1;
      e = sb.pop_front();
      n_tests++;
      if (bif.done !== 1'b1 || k !== e.lat) begin
         n_fail++; $display("FAIL pass_latency: done=%b at cycle 1, want 1", bif.done);
      end
      n_tests++;
      if (bif.dout !== 8'hA5 || bif.count !== 4'd0 || bif.zero !== 1'b0) begin
         n_fail++;
         $display("FAIL pass_result: dout=%h count=%0d zero=%b want A5/0/0",
                  bif.dout, bif.count, bif.zero);
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bif.done === 1'b1 || bif.busy === 1'b1) extra++;
      end
      n_tests++;
      if (extra !== 0 || bif.dout !== 8'hA5) begin
         n_fail++;
         $display("FAIL pass_start_while_busy: %0d active cycles, dout=%h want 0 and A5",
                  extra, bif.dout);
      end
   endtask

   task automatic test_norm;
      exp_t e; int k;
      issue(2'b10, 4'd0, 8'h05);
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== e.lat || bif.dout !== e.dout || bif.count !== e.count || bif.zero !== e.zero) begin
         n_fail++;
         $display("FAIL norm_05: lat=%0d dout=%h count=%0d want lat=%0d dout=%h count=%0d",
                  k, bif.dout, bif.count, e.lat, e.dout, e.count);
      end
      issue(2'b10, 4'd3, 8'h00);
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== 1 || bif.dout !== 8'h00 || bif.count !== 4'd0 || bif.zero !== 1'b1) begin
         n_fail++;
         $display("FAIL norm_zero: lat=%0d dout=%h count=%0d zero=%b want 1/00/0/1",
                  k, bif.dout, bif.count, bif.zero);
      end
      issue(2'b10, 4'd0, 8'h80);
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== 1 || bif.dout !== 8'h80 || bif.count !== 4'd0) begin
         n_fail++;
         $display("FAIL norm_msb: lat=%0d dout=%h count=%0d want 1/80/0", k, bif.dout, bif.count);
      end
   endtask

   task automatic test_reset_mid;
      exp_t e; int k;
      issue(2'b00, 4'd7, 8'hFF);
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({bif.busy, bif.done, bif.dout, bif.count, bif.zero} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b dout=%h count=%0d zero=%b want all 0",
                  bif.busy, bif.done, bif.dout, bif.count, bif.zero);
      end
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      issue(2'b00, 4'd1, 8'h41);
      wait_done(k);
      e = sb.pop_front();
      n_tests++;
      if (k !== 2 || bif.dout !== 8'h82 || bif.count !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_recover: lat=%0d dout=%h count=%0d want 2/82/1", k, bif.dout, bif.count);
      end
   endtask

   task automatic test_random;
      exp_t e; int k;
      for (int i = 0; i < 16; i++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom));
         wait_done(k);
         e = sb.pop_front();
         n_tests++;
         if (k !== e.lat || bif.dout !== e.dout || bif.count !== e.count || bif.zero !== e.zero) begin
            n_fail++;
            $display("FAIL random_%0d: lat=%0d dout=%h count=%0d zero=%b want %0d/%h/%0d/%b",
                     i, k, bif.dout, bif.count, bif.zero, e.lat, e.dout, e.count, e.zero);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e; int dones;
      @(negedge clk);
      bif.start = 1'b1; bif.op = 2'b00; bif.amt = 4'd2; bif.din = 8'h11;
      for (int i = 0; i < 5; i++) sb.push_back(model(2'b00, 4'd2, 8'h11));
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 19) bif.start = 1'b0;
         if (bif.done === 1'b1) begin
            dones++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_tests++;
               if (bif.dout !== e.dout || bif.count !== e.count) begin
                  n_fail++;
                  $display("FAIL b2b_result_%0d: dout=%h count=%0d want %h/%0d",
                           dones, bif.dout, bif.count, e.dout, e.count);
               end
            end
         end
      end
      n_tests++;
      if (dones !== 5 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL b2b_count: %0d done pulses, %0d left queued, want 5 and 0", dones, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_shl();
      test_shr_clamp();
      test_pass_busy();
      test_norm();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
